// File: rtl/light_phase_monitor.sv
// Traffic-light phase monitor.
// Watches the lamp word from a traffic-light controller and checks the
// RED -> GREEN -> YELLOW -> RED order and each phase's minimum and maximum
// dwell time. Any violation sets a sticky error flag and parks the monitor
// in FAULT until clr_err. Every output is a register.
module light_phase_monitor #(
  parameter int RED_MIN    = 10,
  parameter int GREEN_MIN  = 10,
  parameter int YELLOW_MIN = 3,
  parameter int MAX_DWELL  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  lights,
  input  logic        clr_err,
  output logic [2:0]  phase,
  output logic [15:0] dwell_cnt,
  output logic [15:0] cycle_cnt,
  output logic        err_illegal,
  output logic        err_order,
  output logic        err_short,
  output logic        err_timeout,
  output logic        fault
);

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    RED    = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    FAULT  = 3'd4
  } phase_t;

  localparam logic [2:0]  CODE_RED    = 3'b100;
  localparam logic [2:0]  CODE_GREEN  = 3'b001;
  localparam logic [2:0]  CODE_YELLOW = 3'b010;
  localparam logic [15:0] RED_MIN_W    = 16'(RED_MIN);
  localparam logic [15:0] GREEN_MIN_W  = 16'(GREEN_MIN);
  localparam logic [15:0] YELLOW_MIN_W = 16'(YELLOW_MIN);
  localparam logic [15:0] MAX_DWELL_W  = 16'(MAX_DWELL);

  phase_t      state;
  phase_t      next_state;
  logic [2:0]  lights_q;
  logic        change;
  logic        legal;
  logic        active;
  logic        in_order;
  logic [2:0]  next_code;
  logic [15:0] min_dwell;
  logic        viol_illegal;
  logic        viol_order;
  logic        viol_short;
  logic        viol_timeout;
  logic        cycle_done;

  assign phase = state;

  // Classify this edge's sample against the previous one (dwell_cnt still
  // holds how long the old value was held) and pick the next phase.
  always_comb begin
    change     = (lights != lights_q);
    legal      = (lights == CODE_RED) || (lights == CODE_GREEN) ||
                 (lights == CODE_YELLOW);
    active     = (state == RED) || (state == GREEN) || (state == YELLOW);
    next_code  = 3'b000;
    min_dwell  = 16'd0;
    case (state)
      RED: begin
        next_code = CODE_GREEN;
        min_dwell = RED_MIN_W;
      end
      GREEN: begin
        next_code = CODE_YELLOW;
        min_dwell = GREEN_MIN_W;
      end
      YELLOW: begin
        next_code = CODE_RED;
        min_dwell = YELLOW_MIN_W;
      end
      default: begin
        next_code = 3'b000;
        min_dwell = 16'd0;
      end
    endcase

    in_order     = active && change && (lights == next_code);
    viol_illegal = change && !legal && (state != FAULT);
    viol_order   = active && change && legal && (lights != next_code);
    viol_short   = in_order && (dwell_cnt < min_dwell);
    viol_timeout = active && !change && (dwell_cnt == MAX_DWELL_W);
    cycle_done   = (state == YELLOW) && in_order && !viol_short;

    next_state = state;
    if (viol_illegal || viol_order || viol_short || viol_timeout) begin
      next_state = FAULT;
    end else begin
      case (state)
        SYNC:    if (change && (lights == CODE_RED)) next_state = RED;
        RED:     if (in_order) next_state = GREEN;
        GREEN:   if (in_order) next_state = YELLOW;
        YELLOW:  if (in_order) next_state = RED;
        FAULT:   if (clr_err) next_state = SYNC;
        default: next_state = SYNC;
      endcase
    end
  end

  // Register phase, counters and sticky flags; a new violation overrides a
  // coincident clr_err because it is ORed in after the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SYNC;
      lights_q    <= 3'b000;
      dwell_cnt   <= 16'd0;
      cycle_cnt   <= 16'd0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_timeout <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state    <= next_state;
      fault    <= (next_state == FAULT);
      lights_q <= lights;
      if (change) begin
        dwell_cnt <= 16'd1;
      end else if (dwell_cnt != 16'hFFFF) begin
        dwell_cnt <= dwell_cnt + 16'd1;
      end
      if (cycle_done && (cycle_cnt != 16'hFFFF)) begin
        cycle_cnt <= cycle_cnt + 16'd1;
      end
      err_illegal <= (err_illegal && !clr_err) || viol_illegal;
      err_order   <= (err_order   && !clr_err) || viol_order;
      err_short   <= (err_short   && !clr_err) || viol_short;
      err_timeout <= (err_timeout && !clr_err) || viol_timeout;
    end
  end

endmodule

// File: tb/tb_light_phase_monitor.sv
// Directed testbench for light_phase_monitor with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, i.e. after the rising edge that sampled the stimulus.
module tb_light_phase_monitor;

  logic        clk;
  logic        rst;
  logic [2:0]  lights;
  logic        clr_err;
  logic [2:0]  phase;
  logic [15:0] dwell_cnt;
  logic [15:0] cycle_cnt;
  logic        err_illegal;
  logic        err_order;
  logic        err_short;
  logic        err_timeout;
  logic        fault;

  int checks_total;
  int checks_passed;

  light_phase_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .lights      (lights),
    .clr_err     (clr_err),
    .phase       (phase),
    .dwell_cnt   (dwell_cnt),
    .cycle_cnt   (cycle_cnt),
    .err_illegal (err_illegal),
    .err_order   (err_order),
    .err_short   (err_short),
    .err_timeout (err_timeout),
    .fault       (fault)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Drive one lamp word (and clr_err) for a single rising edge.
  task automatic applyStimulus(input logic [2:0] l, input logic c);
    lights  = l;
    clr_err = c;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Hold a lamp word for n rising edges.
  task automatic holdLights(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) applyStimulus(l, 1'b0);
  endtask

  // All four sticky flags must read the given value.
  task automatic checkErrors(input string tag, input logic [3:0] exp);
    checkOutput({tag, "_errs"},
                {12'd0, err_illegal, err_order, err_short, err_timeout},
                {12'd0, exp});
  endtask

  // Directed scenarios.
  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst     = 1'b0;
    lights  = 3'b000;
    clr_err = 1'b0;
    @(negedge clk);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b100, 1'b0);
    checkOutput("rst_phase", 16'(phase), 16'd0);
    checkOutput("rst_dwell", dwell_cnt, 16'd0);
    checkOutput("rst_cycle", cycle_cnt, 16'd0);
    checkOutput("rst_fault", 16'(fault), 16'd0);
    checkErrors("rst", 4'b0000);

    // Clean cycle: RED 10, GREEN 10, YELLOW 3, RED.
    rst = 1'b1;
    applyStimulus(3'b100, 1'b0);
    checkOutput("clean_red_phase", 16'(phase), 16'd1);
    checkOutput("clean_red_dwell", dwell_cnt, 16'd1);
    holdLights(3'b100, 9);
    checkOutput("clean_red_dwell10", dwell_cnt, 16'd10);
    applyStimulus(3'b001, 1'b0);
    checkOutput("clean_green_phase", 16'(phase), 16'd2);
    holdLights(3'b001, 9);
    applyStimulus(3'b010, 1'b0);
    checkOutput("clean_yellow_phase", 16'(phase), 16'd3);
    holdLights(3'b010, 2);
    applyStimulus(3'b100, 1'b0);
    checkOutput("clean_back_red", 16'(phase), 16'd1);
    checkOutput("clean_cycle", cycle_cnt, 16'd1);
    checkErrors("clean", 4'b0000);

    // Short GREEN: RED 10 total, GREEN 4, YELLOW.
    holdLights(3'b100, 9);
    holdLights(3'b001, 4);
    checkOutput("short_green_phase", 16'(phase), 16'd2);
    applyStimulus(3'b010, 1'b0);
    checkErrors("short", 4'b0010);
    checkOutput("short_phase", 16'(phase), 16'd4);
    checkOutput("short_fault", 16'(fault), 16'd1);
    checkOutput("short_dwell", dwell_cnt, 16'd1);
    applyStimulus(3'b010, 1'b1);
    checkOutput("short_clr_phase", 16'(phase), 16'd0);
    checkErrors("short_clr", 4'b0000);
    checkOutput("short_clr_fault", 16'(fault), 16'd0);
    checkOutput("short_clr_cycle", cycle_cnt, 16'd1);

    // In SYNC a legal non-RED code is ignored.
    applyStimulus(3'b001, 1'b0);
    checkOutput("sync_green_phase", 16'(phase), 16'd0);
    checkErrors("sync_green", 4'b0000);

    // Skip GREEN: RED 10 then YELLOW.
    holdLights(3'b100, 10);
    checkOutput("order_red_phase", 16'(phase), 16'd1);
    applyStimulus(3'b010, 1'b0);
    checkErrors("order", 4'b0100);
    checkOutput("order_fault", 16'(fault), 16'd1);
    applyStimulus(3'b010, 1'b1);
    checkOutput("order_clr_phase", 16'(phase), 16'd0);

    // GREEN timeout: boundary at dwell 100, flag on the 101st sample.
    holdLights(3'b100, 10);
    holdLights(3'b001, 100);
    checkOutput("tmo_edge_phase", 16'(phase), 16'd2);
    checkOutput("tmo_edge_dwell", dwell_cnt, 16'd100);
    checkErrors("tmo_edge", 4'b0000);
    applyStimulus(3'b001, 1'b0);
    checkErrors("tmo", 4'b0001);
    checkOutput("tmo_phase", 16'(phase), 16'd4);
    checkOutput("tmo_dwell", dwell_cnt, 16'd101);
    applyStimulus(3'b001, 1'b0);
    checkOutput("tmo_fault_dwell", dwell_cnt, 16'd102);
    checkOutput("tmo_fault_phase", 16'(phase), 16'd4);
    applyStimulus(3'b001, 1'b1);
    checkErrors("tmo_clr", 4'b0000);
    checkOutput("tmo_clr_phase", 16'(phase), 16'd0);

    // Illegal 110 from GREEN with a coincident clr_err.
    holdLights(3'b100, 10);
    holdLights(3'b001, 10);
    applyStimulus(3'b110, 1'b1);
    checkErrors("illegal", 4'b1000);
    checkOutput("illegal_phase", 16'(phase), 16'd4);
    applyStimulus(3'b110, 1'b1);
    checkOutput("illegal_clr_phase", 16'(phase), 16'd0);

    // Reset mid-YELLOW abandons the cycle.
    holdLights(3'b100, 10);
    holdLights(3'b001, 10);
    holdLights(3'b010, 2);
    checkOutput("midrst_yellow", 16'(phase), 16'd3);
    rst = 1'b0;
    applyStimulus(3'b010, 1'b0);
    checkOutput("midrst_phase", 16'(phase), 16'd0);
    checkOutput("midrst_cycle", cycle_cnt, 16'd0);
    checkOutput("midrst_dwell", dwell_cnt, 16'd0);
    rst = 1'b1;
    applyStimulus(3'b100, 1'b0);
    checkOutput("postrst_phase", 16'(phase), 16'd1);
    checkOutput("postrst_cycle", cycle_cnt, 16'd0);
    checkOutput("postrst_dwell", dwell_cnt, 16'd1);
    checkErrors("postrst", 4'b0000);

    // clr_err outside FAULT with clean flags does nothing.
    applyStimulus(3'b100, 1'b1);
    checkOutput("noop_clr_phase", 16'(phase), 16'd1);
    checkOutput("noop_clr_dwell", dwell_cnt, 16'd2);
    checkErrors("noop_clr", 4'b0000);

    // Illegal code seen while in SYNC.
    rst = 1'b0;
    applyStimulus(3'b000, 1'b0);
    rst = 1'b1;
    applyStimulus(3'b011, 1'b0);
    checkErrors("sync_illegal", 4'b1000);
    checkOutput("sync_illegal_phase", 16'(phase), 16'd4);
    checkOutput("sync_illegal_fault", 16'(fault), 16'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/light_phase_monitor.md
LIGHT_PHASE_MONITOR -- requirements
Module: light_phase_monitor

Interface
REQ-001 Parameter RED_MIN, default 10, minimum legal RED dwell in clock cycles.
REQ-002 Parameter GREEN_MIN, default 10, minimum legal GREEN dwell in clock cycles.
REQ-003 Parameter YELLOW_MIN, default 3, minimum legal YELLOW dwell in clock cycles.
REQ-004 Parameter MAX_DWELL, default 100, maximum cycles any phase may hold before timeout; SHALL satisfy MAX_DWELL > every *_MIN and < 16'hFFFF.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 lights  input  3  lamp word from the traffic-light controller; bit2 red, bit1 yellow, bit0 green.
REQ-008 clr_err  input  1  single-cycle pulse clearing sticky errors and leaving FAULT.
REQ-009 phase  output  3  monitor state: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW, 4 FAULT.
REQ-010 dwell_cnt  output  16  cycles the current lights value has been held, saturating.
REQ-011 cycle_cnt  output  16  completed clean RED->GREEN->YELLOW->RED cycles, saturating.
REQ-012 err_illegal  output  1  sticky; lights value outside {100, 001, 010}.
REQ-013 err_order  output  1  sticky; legal code in wrong sequence.
REQ-014 err_short  output  1  sticky; phase left before its *_MIN.
REQ-015 err_timeout  output  1  sticky; phase held longer than MAX_DWELL.
REQ-016 fault  output  1  high exactly when phase == FAULT.

Function
REQ-017 lights SHALL be sampled every rising edge into lights_q; a change is an edge where lights != lights_q.
REQ-018 On a change, dwell_cnt SHALL load 1; otherwise it SHALL increment, saturating at 16'hFFFF.
REQ-019 Short/order checks SHALL use the pre-update dwell_cnt, i.e. cycles the old value was held.
REQ-020 All outputs SHALL be registered; a violation in lights sampled at edge k SHALL be visible on outputs after edge k (one-cycle latency from input change).
REQ-021 SYNC: on a change to 100 -> RED; other legal codes -> stay SYNC, no error; illegal code -> err_illegal, FAULT.
REQ-022 Legal order SHALL be RED(100) -> GREEN(001) -> YELLOW(010) -> RED only.
REQ-023 In RED/GREEN/YELLOW, change to an illegal code (incl. 000, 111, any multi-lamp) -> err_illegal, FAULT.
REQ-024 In RED/GREEN/YELLOW, change to a legal but out-of-order code -> err_order, FAULT.
REQ-025 In-order change with old-phase dwell_cnt < its *_MIN -> err_short, FAULT.
REQ-026 No change while dwell_cnt == MAX_DWELL in RED/GREEN/YELLOW -> err_timeout, FAULT.
REQ-027 Multiple violations on one edge SHALL set every applicable flag.
REQ-028 Clean in-order change -> phase advances to the new code's phase; YELLOW->RED additionally increments cycle_cnt, saturating at 16'hFFFF.
REQ-029 FAULT: no further checks, no counting; dwell_cnt keeps tracking lights; stays FAULT until clr_err.
REQ-030 clr_err SHALL zero all err_* flags and, if in FAULT, move to SYNC; cycle_cnt unaffected.
REQ-031 clr_err coincident with a new violation: violation wins (flag set, FAULT entered).
REQ-032 clr_err outside FAULT with no flags set SHALL have no effect.

Reset
REQ-033 rst low at a rising edge SHALL force phase=SYNC, lights_q=000, dwell_cnt=0, cycle_cnt=0, all err_*=0, fault=0; no checks during reset.
REQ-034 First edge after rst high compares against lights_q=000; reset mid-operation SHALL abandon the current cycle without flagging.

Verification
REQ-035 Reset, then RED 10, GREEN 10, YELLOW 3, RED cycles -> phase 1,2,3,1; cycle_cnt=1; all err_*=0.
REQ-036 RED 10 then GREEN 4 then YELLOW -> err_short=1, phase=4 one cycle after the YELLOW sample.
REQ-037 RED 10 then lights=010 (skip GREEN) -> err_order=1, fault=1; err_illegal=0.
REQ-038 GREEN held 101 cycles -> err_timeout=1 on edge where dwell_cnt was 100; then clr_err pulse -> flags 0, phase=0.
REQ-039 Lights=110 from GREEN with same-edge clr_err -> err_illegal=1, phase=4.
REQ-040 rst low mid-YELLOW, release, drive RED -> phase=1, cycle_cnt=0, dwell_cnt=1, no errors.
